// File: rtl/iob_native_arbiter_pkg.sv
// Shared types and helpers for the native-interface round-robin arbiter.
package iob_native_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Index width for an n-entry select; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
module iob_rr_pick
  import iob_native_arbiter_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IdxW-1:0] enc;
  int unsigned    sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[ptr_i +: N];
    enc     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = IdxW'(i);
    end
    sum = 32'(enc) + 32'(ptr_i);
    if (sum >= N) sum = sum - N;
    idx_o = IdxW'(sum);
    any_o = |req_i;
  end

endmodule

// File: rtl/iob_native_arbiter.sv
// Round-robin arbiter sharing one native slave between N_MASTERS masters.
// A grant is held until the slave returns ready; the next search starts after
// the master just served.
module iob_native_arbiter
  import iob_native_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_MASTERS-1:0]          m_valid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic                          s_valid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic [DATA_W-1:0]             s_rdata_i,
  input  logic                          s_ready_i,
  output logic [N_MASTERS-1:0]          grant_o,
  output logic                          busy_o
);

  localparam int unsigned IdxW  = idx_width(N_MASTERS);
  localparam int unsigned StrbW = DATA_W / 8;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] prio_ptr_q, prio_ptr_d;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic [IdxW-1:0] prio_next;
  int unsigned     gi;

  iob_rr_pick #(
    .N    (N_MASTERS),
    .IdxW (IdxW)
  ) u_pick (
    .req_i (m_valid_i),
    .ptr_i (prio_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // State, grant index and priority pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gnt_idx_q  <= '0;
      prio_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      prio_ptr_q <= prio_ptr_d;
    end
  end

  // Next state: grant in IDLE, release on slave ready in BUSY.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    prio_ptr_d = prio_ptr_q;
    // Wrap without a modulo; for a single master this stays at 0.
    prio_next  = (gnt_idx_q == IdxW'(N_MASTERS - 1)) ? '0 : gnt_idx_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_idx_d = pick_idx;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (s_ready_i) begin
          prio_ptr_d = prio_next;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Route the granted master to the slave and the response back; zeros otherwise.
  always_comb begin
    gi        = 32'(gnt_idx_q);
    s_valid_o = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    m_ready_o = '0;
    m_rdata_o = '0;
    grant_o   = '0;
    busy_o    = 1'b0;
    if (state_q == StBusy) begin
      busy_o                         = 1'b1;
      grant_o[gnt_idx_q]             = 1'b1;
      // Follows the granted master even if it drops early; grant is still held.
      s_valid_o                      = m_valid_i[gnt_idx_q];
      s_addr_o                       = m_addr_i[gi*ADDR_W +: ADDR_W];
      s_wdata_o                      = m_wdata_i[gi*DATA_W +: DATA_W];
      s_wstrb_o                      = m_wstrb_i[gi*StrbW +: StrbW];
      m_ready_o[gnt_idx_q]           = s_ready_i;
      m_rdata_o[gi*DATA_W +: DATA_W] = s_rdata_i;
    end
  end

endmodule
